// File: rtl/ipg_pkg.sv
// ipg_pkg: block-type codes and constants shared by the IPG transmit and receive paths
package ipg_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [7:0] BLOCK_TYPE_CTRL = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_START_0 = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_START_4 = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_OS_START_4 = 8'h66;
  localparam logic [7:0] BLOCK_TYPE_TERM_0 = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_TERM_1 = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_TERM_2 = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_TERM_3 = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_TERM_4 = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_TERM_5 = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_TERM_6 = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_TERM_7 = 8'hff;
  localparam logic [7:0] BT_IPG_REQ = 8'h3c;
  localparam logic [7:0] BT_IPG_REP = 8'hc3;
  localparam logic [63:0] IDLE_BLOCK = 64'h1e;
  typedef enum logic {S_GAP, S_FRAME} state_e;
  function automatic logic is_start(input logic [7:0] t);
    return t == BLOCK_TYPE_START_0 || t == BLOCK_TYPE_START_4 || t == BLOCK_TYPE_OS_START_4;
  endfunction
  function automatic logic is_term(input logic [7:0] t);
    return t inside {BLOCK_TYPE_TERM_0, BLOCK_TYPE_TERM_1, BLOCK_TYPE_TERM_2, BLOCK_TYPE_TERM_3,
                     BLOCK_TYPE_TERM_4, BLOCK_TYPE_TERM_5, BLOCK_TYPE_TERM_6, BLOCK_TYPE_TERM_7};
  endfunction
endpackage

// File: rtl/ipg_rx_fifo.sv
// ipg_rx_fifo: 64-bit synchronous FIFO; a pop frees a slot for a same-cycle push even when full
module ipg_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [63:0] din_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [63:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, cnt;
  logic do_pop, do_push;
  assign cnt = wptr_q - rptr_q;
  assign empty_o = cnt == '0;
  assign full_o = cnt[AW];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(do_push);
      rptr_q <= rptr_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/ipg_rx.sv
// ipg_rx: tracks frame boundaries in the received block stream, pulls IPG request/reply
// blocks out of the gap into FIFOs and replaces them with idle blocks downstream
module ipg_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter logic [7:0] BT_IPG_REQ = 8'h3c,
  parameter logic [7:0] BT_IPG_REP = 8'hc3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  encoded_rx_hdr,
  input  logic [63:0] encoded_rx_data,
  output logic [1:0]  proced_encoded_rx_hdr,
  output logic [63:0] proced_encoded_rx_data,
  output logic [63:0] ipg_req_chunk,
  output logic        ipg_req_valid,
  input  logic        ipg_req_ready,
  output logic [63:0] ipg_reply_chunk,
  output logic        ipg_reply_valid,
  input  logic        ipg_reply_ready,
  output logic        rx_err,
  output logic [7:0]  drop_cnt
);
  import ipg_pkg::*;
  state_e state_q, state_d;
  logic [1:0] hdr_q;
  logic [63:0] data_q;
  logic err_q, err_d, ext_req, ext_rep, req_full, rep_full, req_empty, rep_empty, drop;
  logic [7:0] drop_q;
  logic [7:0] btype;
  assign btype = encoded_rx_data[7:0];
  always_comb begin
    state_d = state_q;
    err_d = 1'b0;
    ext_req = 1'b0;
    ext_rep = 1'b0;
    if (encoded_rx_hdr != SYNC_DATA && encoded_rx_hdr != SYNC_CTRL) err_d = 1'b1;
    else if (state_q == S_GAP) begin
      if (encoded_rx_hdr == SYNC_DATA) err_d = 1'b1;
      else if (btype == BT_IPG_REQ) ext_req = 1'b1;
      else if (btype == BT_IPG_REP) ext_rep = 1'b1;
      else if (is_start(btype)) state_d = S_FRAME;
    end else if (encoded_rx_hdr == SYNC_CTRL) begin
      if (is_term(btype)) state_d = S_GAP;
      else begin
        err_d = 1'b1;
        // IPG blocks inside a frame are flagged but do not end the frame
        if (btype != BT_IPG_REQ && btype != BT_IPG_REP) state_d = S_GAP;
      end
    end
  end
  assign drop = (ext_req & req_full & ~(ipg_req_valid & ipg_req_ready)) |
                (ext_rep & rep_full & ~(ipg_reply_valid & ipg_reply_ready));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_GAP;
      hdr_q <= SYNC_CTRL;
      data_q <= IDLE_BLOCK;
      err_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q <= (ext_req | ext_rep) ? SYNC_CTRL : encoded_rx_hdr;
      data_q <= (ext_req | ext_rep) ? IDLE_BLOCK : encoded_rx_data;
      err_q <= err_d;
      drop_q <= (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    end
  end
  ipg_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk(clk), .reset(reset), .push_i(ext_req), .din_i(encoded_rx_data), .pop_i(ipg_req_ready),
    .full_o(req_full), .empty_o(req_empty), .head_o(ipg_req_chunk)
  );
  ipg_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rep_fifo (
    .clk(clk), .reset(reset), .push_i(ext_rep), .din_i(encoded_rx_data), .pop_i(ipg_reply_ready),
    .full_o(rep_full), .empty_o(rep_empty), .head_o(ipg_reply_chunk)
  );
  assign ipg_req_valid = ~req_empty;
  assign ipg_reply_valid = ~rep_empty;
  assign proced_encoded_rx_hdr = hdr_q;
  assign proced_encoded_rx_data = data_q;
  assign rx_err = err_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_ipg_rx.sv
// tb_ipg_rx: randomized and directed stimulus against a queue-based reference model with a scoreboard
module tb_ipg_rx;
  localparam int DEPTH = 8;
  localparam logic [63:0] IDLE = 64'h1e;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] hdr = 2'b01;
  logic [63:0] data = IDLE;
  logic req_ready = 1'b0, rep_ready = 1'b0;
  logic [1:0] o_hdr;
  logic [63:0] o_data, req_chunk, rep_chunk;
  logic req_valid, rep_valid, rx_err;
  logic [7:0] drop_cnt;
  typedef struct {
    logic [1:0] h; logic [63:0] d; logic err;
    logic rqv; logic [63:0] rqh; logic rpv; logic [63:0] rph; logic [7:0] drop;
  } exp_t;
  exp_t exp_q[$];
  logic [63:0] req_m[$], rep_m[$];
  bit in_frame;
  int drop_m, checks, errors;
  logic [7:0] starts [3] = '{8'h78, 8'h33, 8'h66};
  logic [7:0] terms [8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
  logic [7:0] others [4] = '{8'h1e, 8'h4b, 8'h2d, 8'h55};

  ipg_rx dut (
    .clk(clk), .reset(reset), .encoded_rx_hdr(hdr), .encoded_rx_data(data),
    .proced_encoded_rx_hdr(o_hdr), .proced_encoded_rx_data(o_data),
    .ipg_req_chunk(req_chunk), .ipg_req_valid(req_valid), .ipg_req_ready(req_ready),
    .ipg_reply_chunk(rep_chunk), .ipg_reply_valid(rep_valid), .ipg_reply_ready(rep_ready),
    .rx_err(rx_err), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, req);
    end
  endfunction

  function automatic logic [63:0] blk(input logic [7:0] t);
    return {$urandom, $urandom} & ~64'hff | {56'd0, t};
  endfunction

  task automatic send(input logic [1:0] h, input logic [63:0] d, input bit rq, input bit rp);
    exp_t e;
    bit er = 0, xr = 0, xp = 0;
    logic [7:0] t = d[7:0];
    @(negedge clk);
    hdr = h; data = d; req_ready = rq; rep_ready = rp;
    if (h == 2'b00 || h == 2'b11) er = 1;
    else if (!in_frame) begin
      if (h == 2'b10) er = 1;
      else if (t == 8'h3c) xr = 1;
      else if (t == 8'hc3) xp = 1;
      else if (t inside {8'h78, 8'h33, 8'h66}) in_frame = 1;
    end else if (h == 2'b01) begin
      if (t inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff}) in_frame = 0;
      else begin
        er = 1;
        if (!(t inside {8'h3c, 8'hc3})) in_frame = 0;
      end
    end
    if (rq && req_m.size() > 0) void'(req_m.pop_front());
    if (rp && rep_m.size() > 0) void'(rep_m.pop_front());
    if (xr) begin
      if (req_m.size() < DEPTH) req_m.push_back(d); else if (drop_m < 255) drop_m++;
    end
    if (xp) begin
      if (rep_m.size() < DEPTH) rep_m.push_back(d); else if (drop_m < 255) drop_m++;
    end
    e.h = (xr || xp) ? 2'b01 : h;
    e.d = (xr || xp) ? IDLE : d;
    e.err = er;
    e.rqv = req_m.size() > 0;
    e.rqh = e.rqv ? req_m[0] : '0;
    e.rpv = rep_m.size() > 0;
    e.rph = e.rpv ? rep_m[0] : '0;
    e.drop = 8'(drop_m);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; hdr = 2'b01; data = IDLE; req_ready = 0; rep_ready = 0;
    exp_q.delete(); req_m.delete(); rep_m.delete(); in_frame = 0; drop_m = 0;
    #1;
    chk("rst_hdr", 64'(o_hdr), 64'h1);
    chk("rst_data", o_data, IDLE);
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_rep_valid", 64'(rep_valid), 0);
    chk("rst_err", 64'(rx_err), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_hdr", 64'(o_hdr), 64'(e.h));
        chk("out_data", o_data, e.d);
        chk("rx_err", 64'(rx_err), 64'(e.err));
        chk("req_valid", 64'(req_valid), 64'(e.rqv));
        if (e.rqv) chk("req_chunk", req_chunk, e.rqh);
        chk("rep_valid", 64'(rep_valid), 64'(e.rpv));
        if (e.rpv) chk("rep_chunk", rep_chunk, e.rph);
        chk("drop_cnt", 64'(drop_cnt), 64'(e.drop));
      end
    end
  end

  initial begin
    int k;
    bit rq, rp;
    do_reset();
    send(2'b01, IDLE, 0, 0);
    send(2'b01, 64'h11223344553c5a3c, 0, 0);
    send(2'b01, IDLE, 0, 0);
    send(2'b01, IDLE, 1, 0);
    send(2'b01, blk(8'h78), 0, 0);
    repeat (3) send(2'b10, {$urandom, $urandom}, 0, 0);
    send(2'b01, blk(8'hc3), 0, 0);
    send(2'b01, blk(8'hff), 0, 0);
    repeat (10) send(2'b01, blk(8'h3c), 0, 0);
    send(2'b01, blk(8'h3c), 1, 0);
    repeat (10) send(2'b01, IDLE, 1, 0);
    send(2'b11, {$urandom, $urandom}, 0, 0);
    send(2'b10, {$urandom, $urandom}, 0, 0);
    repeat (3) send(2'b01, blk(8'h3c), 0, 0);
    send(2'b01, blk(8'h33), 0, 0);
    send(2'b10, {$urandom, $urandom}, 0, 0);
    do_reset();
    send(2'b01, blk(8'h3c), 0, 0);
    send(2'b01, IDLE, 1, 0);
    send(2'b01, IDLE, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 11);
      rq = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rp = ((i / 150) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      case (k)
        0, 1: send(2'b01, blk(8'h3c), rq, rp);
        2, 3: send(2'b01, blk(8'hc3), rq, rp);
        4: send(2'b01, blk(starts[$urandom_range(0, 2)]), rq, rp);
        5, 6, 7: send(2'b10, {$urandom, $urandom}, rq, rp);
        8: send(2'b01, blk(terms[$urandom_range(0, 7)]), rq, rp);
        9: send($urandom_range(0, 1) ? 2'b11 : 2'b00, {$urandom, $urandom}, rq, rp);
        10: send(2'b01, blk(others[$urandom_range(0, 3)]), rq, rp);
        default: send(2'b01, IDLE, rq, rp);
      endcase
    end
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
